// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular buffer of (address, instruction) pairs.
// Optional zero-latency empty-queue bypass is enabled by defining INST_QUEUE_BYPASS_EN.
module inst_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_addr,
    input  logic [ILEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_addr,
    output logic [ILEN-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [ILEN-1:0] INST_NOP = ILEN'(32'h00000033);

    logic [XLEN-1:0] r_addr [DEPTH];
    logic [ILEN-1:0] r_inst [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;

    logic w_empty;
    logic w_full;
    logic w_byp;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

`ifdef INST_QUEUE_BYPASS_EN
    // Empty queue forwards the fetch entry straight to decode.
    assign w_byp = w_empty & ~flush & ~reset & in_valid;
`else
    assign w_byp = 1'b0;
`endif

    assign in_ready  = ~w_full & ~reset;
    // A bypassed entry that decode takes this cycle is never written.
    assign w_push    = in_valid & in_ready & ~flush & ~(w_byp & out_ready);
    assign w_pop     = ~w_empty & out_ready & ~flush;

    assign out_valid = ~w_empty | w_byp;
    assign out_addr  = w_byp   ? in_addr :
                       w_empty ? '0      : r_addr[r_rptr[AW-1:0]];
    assign out_inst  = w_byp   ? in_inst :
                       w_empty ? INST_NOP : r_inst[r_rptr[AW-1:0]];
    assign count     = r_wptr - r_rptr;

    // Storage is not reset; the empty mux hides stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr[AW-1:0]] <= in_addr;
            r_inst[r_wptr[AW-1:0]] <= in_inst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed table-driven bench for inst_queue (DEPTH=4, XLEN=ILEN=32).
module tb_inst_queue;

    localparam logic [31:0] NOP = 32'h00000033;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] ia;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_head;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    inst_queue #(.XLEN(32), .ILEN(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_inst(out_inst),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hABCD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic iv, input logic [31:0] ia, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [31:0] e_head,
                       input logic [2:0] e_cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ia = ia; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_head = e_head; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic check_idle(input string tag, input logic e_ir);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".out_addr"},  out_addr,       32'd0);
        chk({tag, ".out_inst"},  out_inst,       NOP);
        chk({tag, ".count"},     32'(count),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        eov;
        logic [31:0] eoa;
        logic [31:0] eoi;

        // fill to full, reject a push, drain in order
        add(0, 1, 32'h100, 0, 1, 0, 0,       0);
        add(0, 1, 32'h104, 0, 1, 1, 32'h100, 1);
        add(0, 1, 32'h108, 0, 1, 1, 32'h100, 2);
        add(0, 1, 32'h10C, 0, 1, 1, 32'h100, 3);
        add(0, 1, 32'h110, 0, 0, 1, 32'h100, 4);
        add(0, 0, 0,       1, 0, 1, 32'h100, 4);
        add(0, 0, 0,       1, 1, 1, 32'h104, 3);
        add(0, 0, 0,       1, 1, 1, 32'h108, 2);
        add(0, 0, 0,       1, 1, 1, 32'h10C, 1);
        add(0, 0, 0,       0, 1, 0, 0,       0);
        // streaming at count=1 across the pointer wrap
        add(0, 1, 32'h200, 0, 1, 0, 0,       0);
        for (int k = 0; k < 10; k++)
            add(0, 1, 32'h204 + 32'(4*k), 1, 1, 1, 32'h200 + 32'(4*k), 1);
        add(0, 0, 0,       1, 1, 1, 32'h228, 1);
        add(0, 0, 0,       0, 1, 0, 0,       0);
        // flush at count=3 with concurrent push and pop
        add(0, 1, 32'h300, 0, 1, 0, 0,       0);
        add(0, 1, 32'h304, 0, 1, 1, 32'h300, 1);
        add(0, 1, 32'h308, 0, 1, 1, 32'h300, 2);
        add(1, 1, 32'h30C, 1, 1, 1, 32'h300, 3);
        add(0, 0, 0,       0, 1, 0, 0,       0);
        add(0, 1, 32'h310, 0, 1, 0, 0,       0);
        add(0, 0, 0,       1, 1, 1, 32'h310, 1);
        add(0, 0, 0,       0, 1, 0, 0,       0);
        // full with pop and push offered together
        add(0, 1, 32'h400, 0, 1, 0, 0,       0);
        add(0, 1, 32'h404, 0, 1, 1, 32'h400, 1);
        add(0, 1, 32'h408, 0, 1, 1, 32'h400, 2);
        add(0, 1, 32'h40C, 0, 1, 1, 32'h400, 3);
        add(0, 1, 32'h410, 1, 0, 1, 32'h400, 4);
        add(0, 0, 0,       1, 1, 1, 32'h404, 3);
        add(0, 0, 0,       1, 1, 1, 32'h408, 2);
        add(0, 0, 0,       1, 1, 1, 32'h40C, 1);
        add(0, 0, 0,       0, 1, 0, 0,       0);

        // reset state, then first cycle after deassertion
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle("post_rst", 1'b1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_addr   = vecs[i].ia;
            in_inst   = inst_of(vecs[i].ia);
            out_ready = vecs[i].ordy;
            @(negedge clk);
            eov = vecs[i].e_ov;
            eoa = vecs[i].e_ov ? vecs[i].e_head : 32'd0;
            eoi = vecs[i].e_ov ? inst_of(vecs[i].e_head) : NOP;
`ifdef INST_QUEUE_BYPASS_EN
            if (vecs[i].e_cnt == 3'd0 && vecs[i].iv && !vecs[i].fl) begin
                eov = 1'b1;
                eoa = vecs[i].ia;
                eoi = inst_of(vecs[i].ia);
            end
`endif
            chk($sformatf("v%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(eov));
            chk($sformatf("v%0d.out_addr", i),  out_addr,       eoa);
            chk($sformatf("v%0d.out_inst", i),  out_inst,       eoi);
            chk($sformatf("v%0d.count", i),     32'(count),     32'(vecs[i].e_cnt));
            @(posedge clk);
            #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // reset asserted mid-operation with two entries held
        in_valid = 1'b1;
        in_addr  = 32'h600; in_inst = inst_of(32'h600);
        @(posedge clk); #1;
        in_addr  = 32'h604; in_inst = inst_of(32'h604);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid.count_before", 32'(count), 32'd2);
        #2 reset = 1'b1;
        #1;
        check_idle("mid_rst", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle("mid_post_rst", 1'b1);
        @(posedge clk); #1;

        // empty queue, entry offered with decode ready
        in_valid  = 1'b1;
        in_addr   = 32'h500;
        in_inst   = 32'h00500093;
        out_ready = 1'b1;
        @(negedge clk);
`ifdef INST_QUEUE_BYPASS_EN
        chk("byp.out_valid", 32'(out_valid), 32'd1);
        chk("byp.out_inst",  out_inst,       32'h00500093);
        chk("byp.out_addr",  out_addr,       32'h500);
`else
        chk("byp.out_valid", 32'(out_valid), 32'd0);
        chk("byp.out_inst",  out_inst,       NOP);
        chk("byp.out_addr",  out_addr,       32'd0);
`endif
        chk("byp.count", 32'(count), 32'd0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
`ifdef INST_QUEUE_BYPASS_EN
        chk("byp_next.out_valid", 32'(out_valid), 32'd0);
        chk("byp_next.count",     32'(count),     32'd0);
`else
        chk("byp_next.out_valid", 32'(out_valid), 32'd1);
        chk("byp_next.out_inst",  out_inst,       32'h00500093);
        chk("byp_next.out_addr",  out_addr,       32'h500);
        chk("byp_next.count",     32'(count),     32'd1);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_idle("end", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
